// File: rtl/serial_alu_if.sv
// Handshake and operand/result bundle between a serial ALU and its requester.
interface serial_alu_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [2:0]       op;
  logic             ina;
  logic             inb;
  logic             out;
  logic             regout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, ina, inb,
    input  out, regout, busy, done, result, zero
  );

  modport slave (
    input  start, op, ina, inb,
    output out, regout, busy, done, result, zero
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU: consumes operands LSB-first, one bit per clock, and assembles
// a parallel result with carry and zero flags behind a start/busy/done handshake.
module serial_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_alu_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_q, out_d;
  logic             regout_q, regout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             b_eff;
  logic             arith;
  logic             bit_r;
  logic             bit_c;

  // SUB and INC start with carry-in set: A + ~B + 1 and A + 0 + 1.
  function automatic logic init_carry(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_INC);
  endfunction

  // One-bit datapath for the current bit position.
  always_comb begin
    b_eff = bus.inb;
    arith = 1'b0;
    bit_r = 1'b0;
    case (op_q)
      OP_ADD: arith = 1'b1;
      OP_SUB: begin
        arith = 1'b1;
        b_eff = ~bus.inb;
      end
      OP_INC: begin
        arith = 1'b1;
        b_eff = 1'b0;
      end
      default: arith = 1'b0;
    endcase

    case (op_q)
      OP_AND:  bit_r = bus.ina & bus.inb;
      OP_OR:   bit_r = bus.ina | bus.inb;
      OP_XOR:  bit_r = bus.ina ^ bus.inb;
      OP_NAND: bit_r = ~(bus.ina & bus.inb);
      OP_NOR:  bit_r = ~(bus.ina | bus.inb);
      default: bit_r = bus.ina ^ b_eff ^ carry_q;
    endcase

    bit_c = arith & ((bus.ina & b_eff) | (bus.ina & carry_q) | (b_eff & carry_q));
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    out_d    = out_q;
    regout_d = regout_q;
    zero_d   = zero_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d     = bus.op;
          result_d = '0;
          carry_d  = init_carry(bus.op);
          cnt_d    = '0;
          state_d  = ST_RUN;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        result_d = {bit_r, result_q[WIDTH-1:1]};
        out_d    = bit_r;
        carry_d  = bit_c;
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          regout_d = bit_c;
          zero_d   = (result_d == '0);
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      out_q    <= 1'b0;
      regout_q <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      out_q    <= out_d;
      regout_q <= regout_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.regout = regout_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Randomized self-checking bench for serial_alu against an arithmetic reference model.
module tb_serial_alu;

  localparam int unsigned W = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_INC  = 3'd7;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  serial_alu_if #(.WIDTH(W)) bus ();

  serial_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic on the operands.
  task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic c);
    logic [8:0] s;
    c = 1'b0;
    case (o)
      OP_ADD:  begin s = 9'(a) + 9'(b); r = s[7:0]; c = s[8]; end
      OP_SUB:  begin r = a - b; c = (a >= b); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: begin s = 9'(a) + 9'd1; r = s[7:0]; c = s[8]; end
    endcase
  endtask

  // Called at a negedge; issues start there and returns at the negedge where done is high.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input bit inject);
    logic [7:0] er;
    logic       ec;
    model(o, a, b, er, ec);
    bus.start = 1'b1;
    bus.op    = o;
    bus.ina   = 1'($urandom);
    bus.inb   = 1'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    chk("busy_rise", 32'(bus.busy), 32'd1);
    chk("done_low_at_run", 32'(bus.done), 32'd0);
    bus.ina = a[0];
    bus.inb = (o == OP_INC) ? 1'($urandom) : b[0];
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      chk("out_bit", 32'(bus.out), 32'(er[k]));
      if (k < int'(W) - 1) begin
        chk("busy_run", 32'(bus.busy), 32'd1);
        chk("done_run", 32'(bus.done), 32'd0);
        bus.ina   = a[k+1];
        bus.inb   = (o == OP_INC) ? 1'($urandom) : b[k+1];
        bus.start = inject && (k == 3);
        if (inject && k == 3) bus.op = OP_XOR;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("result", 32'(bus.result), 32'(er));
    chk("regout", 32'(bus.regout), 32'(ec));
    chk("zero", 32'(bus.zero), 32'(er == 8'h00));
  endtask

  task automatic idle_gap();
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.ina   = 1'b0;
    bus.inb   = 1'b0;

    #12;
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_regout", 32'(bus.regout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_rst", 32'(bus.busy), 32'd0);

    run_op(OP_ADD, 8'hFF, 8'h01, 1'b0); idle_gap();
    run_op(OP_SUB, 8'h05, 8'h07, 1'b0); idle_gap();
    run_op(OP_SUB, 8'h07, 8'h05, 1'b0); idle_gap();
    run_op(OP_XOR, 8'hA5, 8'h3C, 1'b0); idle_gap();
    run_op(OP_NAND, 8'hF0, 8'hCC, 1'b0); idle_gap();
    run_op(OP_NOR, 8'hF0, 8'h0C, 1'b0); idle_gap();
    run_op(OP_INC, 8'h7F, 8'h00, 1'b0); idle_gap();
    run_op(OP_INC, 8'hFF, 8'h00, 1'b0); idle_gap();

    // Mid-run start is ignored; then a start in the done cycle chains with no bubble.
    run_op(OP_ADD, 8'h3A, 8'h4B, 1'b1);
    run_op(OP_SUB, 8'h10, 8'h20, 1'b0);
    run_op(OP_OR, 8'h81, 8'h18, 1'b0); idle_gap();

    for (int i = 0; i < 24; i++) begin
      logic [2:0] o;
      logic [7:0] a;
      logic [7:0] b;
      o = 3'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(o, a, b, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 0) idle_gap();
    end
    idle_gap();

    // Asynchronous reset in the middle of a run.
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.ina = 1'b1;
      bus.inb = 1'b0;
      @(negedge clk);
    end
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    chk("pre_rst_result", 32'(bus.result), 32'hF0);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_out", 32'(bus.out), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_done_in_rst", 32'(bus.done), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_post_rst", 32'(bus.busy), 32'd0);
      chk("no_done_post_rst", 32'(bus.done), 32'd0);
    end
    run_op(OP_ADD, 8'h12, 8'h34, 1'b0); idle_gap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
Bit-serial, parametrised-width ALU. It consumes two operands LSB-first on single-bit inputs `ina`/`inb`, one bit per clock. It keeps a carry/borrow flip-flop across bits and assembles the result in an internal shift register. It fills the previously empty `alu` slot. Its sequencing is driven by a small FSM with a bit counter and a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset: asynchronous, active-low. Clears all state immediately while low.
- start  input  1  request a new operation; sampled only when not busy.
- op  input  3  operation code; latched on an accepted start.
- ina  input  1  operand A serial bit, LSB first.
- inb  input  1  operand B serial bit, LSB first.
- out  output  1  registered serial result bit of the most recently processed bit position.
- regout  output  1  carry flag: final carry-out for arithmetic ops, 0 for logic ops.
- busy  output  1  high while operand bits are being consumed.
- done  output  1  one-cycle pulse; `result`/`regout`/`zero` are valid from this cycle.
- result  output  WIDTH  parallel result; held until the next accepted start.
- zero  output  1  high when `result` == 0; valid with `done`, held afterwards.

Behaviour:
- Reset (`rst` low): state IDLE; bit counter 0; latched op 0; carry 0. All outputs are 0: `out`, `regout`, `busy`, `done`, `result`, `zero`.
- FSM states:
  - IDLE: if `start`, latch `op`, clear `result`, init carry, counter := 0, go to RUN.
  - RUN: each edge samples `ina`/`inb` for bit k = counter. It computes bit r and new carry, then shifts r into `result` MSB (right shift), so after WIDTH bits bit 0 sits at `result[0]`. It sets `out` := r and counter := counter+1. At k = WIDTH-1, go to DONE.
  - DONE: `done` = 1 for exactly this cycle, `regout` and `zero` updated. Behaves as IDLE: a `start` here is accepted and goes straight to RUN (back-to-back ops, no bubble). Otherwise go to IDLE.
- `busy` = 1 exactly in RUN.
- Latency: start accepted at edge E0; bits sampled at E1..E_WIDTH; `done` high in the cycle after E_WIDTH. Throughput is one op per WIDTH+1 cycles.
- Operand bits are don't-care outside RUN.
- op encoding (a, b = current bits; c = carry):
  - 000 ADD: r = a^b^c, c' = maj(a,b,c), init c = 0.
  - 001 SUB: b replaced by ~b, init c = 1. Final carry 1 = no borrow (A >= B).
  - 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR: bitwise, carry forced 0.
  - 111 INC A: b forced 0, init c = 1. `inb` ignored.
- `regout` = final carry for ADD/SUB/INC, 0 otherwise. It is updated only on entry to DONE and holds between ops.
- Arithmetic is modulo 2^WIDTH; no overflow flag.
- Boundary conditions:
  - `start` while busy: ignored; the latched op is not disturbed.
  - `op` changes during RUN: ignored.
  - `start` held continuously: ops run back-to-back.
  - Reset mid-operation: abort immediately, no `done`, all outputs 0.
  - After reset release, FSM sits in IDLE until a `start` is seen.
  - Counter width: clog2(WIDTH). Terminal count WIDTH-1; no wrap beyond it.

Test Plan:
- WIDTH=8, ADD, A=0xFF, B=0x01 -> `busy` high 8 cycles; `done` 9 cycles after the start edge; `result`=0x00, `regout`=1, `zero`=1. `out` sequence is eight 0s.
- SUB, A=0x05, B=0x07 -> `result`=0xFE, `regout`=0 (borrow), `zero`=0. SUB, A=0x07, B=0x05 -> 0x02, `regout`=1.
- XOR A=0xA5, B=0x3C -> 0x99, `regout`=0. NAND A=0xF0, B=0xCC -> 0x3F. NOR A=0xF0, B=0x0C -> 0x03.
- INC A=0x7F with random `inb` -> 0x80, `regout`=0. INC A=0xFF -> 0x00, `regout`=1, `zero`=1.
- Start ADD; after 4 bits pulse `start` with op=XOR -> ignored, ADD result correct. Then assert `start` during the `done` cycle -> next op runs with no idle cycle and `busy` rises the following cycle.
- Drive `rst` low after 4 RUN bits -> `busy`, `result`, `out` go 0 asynchronously and no `done` occurs. After release, a fresh ADD 0x12+0x34 -> 0x46.
